// File: rtl/cache_line_mover.sv
// Moves one 4-word cache line between the cache line port and a 16-bit memory port.
// Fill: memory beats -> line buffer -> cache write. Writeback: cache read -> memory beats.
module cache_line_mover #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [13:0] req_addr,
  output logic        req_ready,
  output logic        done,
  output logic        err,
  input  logic        cache_en,
  output logic [3:0]  cache_wen,
  output logic [13:0] cache_addr,
  output logic [63:0] cache_wdata,
  input  logic [63:0] cache_rdata,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_write,
  output logic [13:0] mem_cmd_addr,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [15:0] mem_wdata
);

  localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StRbeat,
    StCwrite,
    StCread,
    StClatch,
    StWbeat,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [63:0] line_q, line_d;
  logic [1:0]  beat_q, beat_d;
  logic [9:0]  wait_q, wait_d;
  logic        err_q, err_d;

  logic        hs;
  logic        timeout;
  logic [5:0]  word_lsb;

  assign timeout  = (wait_q == TimeoutCnt);
  assign word_lsb = {beat_q, 4'h0};

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    write_d       = write_q;
    line_d        = line_q;
    beat_d        = beat_q;
    wait_d        = wait_q;
    err_d         = err_q;
    hs            = 1'b0;
    req_ready     = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    cache_wen     = 4'h0;
    cache_addr    = 14'h0;
    cache_wdata   = 64'h0;
    mem_cmd_valid = 1'b0;
    mem_cmd_write = 1'b0;
    mem_cmd_addr  = 14'h0;
    mem_wvalid    = 1'b0;
    mem_wdata     = 16'h0;

    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          err_d   = 1'b0;
          beat_d  = 2'd0;
          state_d = req_write ? StCread : StCmd;
        end
      end
      StCmd: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          mem_cmd_valid = 1'b1;
          mem_cmd_write = write_q;
          mem_cmd_addr  = addr_q;
          if (mem_cmd_ready) begin
            hs      = 1'b1;
            beat_d  = 2'd0;
            state_d = write_q ? StWbeat : StRbeat;
          end
        end
      end
      StRbeat: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (mem_rvalid) begin
          hs                     = 1'b1;
          line_d[word_lsb +: 16] = mem_rdata;
          beat_d                 = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = StCwrite;
        end
      end
      StCwrite: begin
        // Held steady until the core releases the line port.
        cache_wen   = 4'hF;
        cache_addr  = addr_q;
        cache_wdata = line_q;
        if (cache_en) state_d = StDone;
      end
      StCread: begin
        cache_addr = addr_q;
        if (cache_en) state_d = StClatch;
      end
      StClatch: begin
        line_d  = cache_rdata;
        state_d = StCmd;
      end
      StWbeat: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          mem_wvalid = 1'b1;
          mem_wdata  = line_q[word_lsb +: 16];
          if (mem_wready) begin
            hs     = 1'b1;
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Counts idle cycles of the current memory handshake only.
    if (hs || (state_d != state_q)) begin
      wait_d = 10'd0;
    end else if ((state_q == StCmd) || (state_q == StRbeat) || (state_q == StWbeat)) begin
      wait_d = wait_q + 10'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= 14'h0;
      write_q <= 1'b0;
      line_q  <= 64'h0;
      beat_q  <= 2'd0;
      wait_q  <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_line_mover.sv
// Bench for cache_line_mover: directed scenarios plus random fills/writebacks
// checked against a line-level model of what each transfer must produce.
module tb_cache_line_mover;

  localparam int unsigned TO = 8;
  localparam logic [117:0] ResetOuts = {1'b1, 117'b0};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_write;
  logic [13:0] req_addr;
  logic        req_ready, done, err;
  logic        cache_en;
  logic [3:0]  cache_wen;
  logic [13:0] cache_addr;
  logic [63:0] cache_wdata, cache_rdata;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [13:0] mem_cmd_addr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        mem_wvalid, mem_wready;
  logic [15:0] mem_wdata;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  logic [77:0] commit_q[$];
  logic [81:0] stall_q[$];
  logic [14:0] cmd_q[$];
  logic [15:0] wb_q[$];
  bit          done_err_q[$];
  int unsigned done_cyc_q[$];
  int unsigned acc_cyc_q[$];

  cache_line_mover #(.TIMEOUT(TO)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .done          (done),
    .err           (err),
    .cache_en      (cache_en),
    .cache_wen     (cache_wen),
    .cache_addr    (cache_addr),
    .cache_wdata   (cache_wdata),
    .cache_rdata   (cache_rdata),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_write (mem_cmd_write),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .mem_wvalid    (mem_wvalid),
    .mem_wready    (mem_wready),
    .mem_wdata     (mem_wdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Passive observer: records every handshake/commit away from the clock edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (req_valid && req_ready) acc_cyc_q.push_back(cyc);
      if (cache_wen != 4'h0 && cache_en) commit_q.push_back({cache_addr, cache_wdata});
      if (cache_wen != 4'h0 && !cache_en) stall_q.push_back({cache_wen, cache_addr, cache_wdata});
      if (mem_cmd_valid && mem_cmd_ready) cmd_q.push_back({mem_cmd_write, mem_cmd_addr});
      if (mem_wvalid && mem_wready) wb_q.push_back(mem_wdata);
      if (done) begin
        done_err_q.push_back(err);
        done_cyc_q.push_back(cyc);
      end
    end
  end

  function automatic logic [117:0] all_outs();
    return {req_ready, done, err, cache_wen, cache_addr, cache_wdata, mem_cmd_valid,
            mem_cmd_write, mem_cmd_addr, mem_wvalid, mem_wdata};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    commit_q.delete();
    stall_q.delete();
    cmd_q.delete();
    wb_q.delete();
    done_err_q.delete();
    done_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  task automatic idle_inputs();
    req_valid     = 1'b0;
    mem_cmd_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_wready    = 1'b0;
    cache_en      = 1'b0;
    mem_rdata     = 16'($urandom());
    cache_rdata   = {$urandom(), $urandom()};
  endtask

  task automatic do_accept(input logic [13:0] a, input logic w, input bit keep, output bit ok);
    int n = 0;
    req_addr  = a;
    req_write = w;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    ok = req_ready;
    tick();
    if (!keep) req_valid = 1'b0;
  endtask

  // Starts in CMD, ends right after the cache commit edge.
  task automatic fill_body(input logic [15:0] beats [4], input int unsigned gmax,
                           input int unsigned stall);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'($urandom());
    repeat ($urandom_range(gmax, 0)) tick();
    mem_rvalid    = 1'b0;
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(gmax, 0)) begin
        mem_rdata = 16'($urandom());
        tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = beats[k];
      tick();
      mem_rvalid = 1'b0;
    end
    cache_en = 1'b0;
    repeat (stall) tick();
    cache_en = 1'b1;
    tick();
    cache_en = 1'($urandom_range(1, 0));
  endtask

  // Starts in CREAD, ends right after the last write-beat edge.
  task automatic wb_body(input logic [63:0] line, input int unsigned gmax,
                         input int unsigned stall);
    cache_en = 1'b0;
    repeat (stall) begin
      cache_rdata = {$urandom(), $urandom()};
      tick();
    end
    cache_en = 1'b1;
    tick();
    cache_en    = 1'($urandom_range(1, 0));
    cache_rdata = line;
    tick();
    cache_rdata = {$urandom(), $urandom()};
    repeat ($urandom_range(gmax, 0)) tick();
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(gmax, 0)) tick();
      mem_wready = 1'b1;
      tick();
      mem_wready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 1'b1;
    #3;
    checks++;
    if (all_outs() !== ResetOuts)
      $display("FAIL reset_outs: got %h expected %h", all_outs(), ResetOuts);
    repeat (2) tick();
    req_valid = 1'b0;
    reset_n   = 1'b1;
    tick();
    checks++;
    if (all_outs() !== ResetOuts) begin
      errors++;
      $display("FAIL reset_release_outs: got %h expected %h", all_outs(), ResetOuts);
    end
  endtask

  task automatic test_fill();
    logic [15:0] beats [4];
    logic [63:0] exp_line;
    bit ok;
    beats    = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp_line = '0;
    for (int k = 0; k < 4; k++) exp_line |= 64'(beats[k]) << (16 * k);
    clear_q();
    do_accept(14'h0123, 1'b0, 1'b0, ok);
    fill_body(beats, 0, 0);
    for (int n = 0; n < 10 && done_err_q.size() == 0; n++) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_accept: req_ready got 0 expected 1"); end
    checks++;
    if (commit_q.size() != 1) begin
      errors++;
      $display("FAIL fill_commit_count: got %0d expected 1", commit_q.size());
    end else begin
      checks++;
      if (commit_q[0] !== {14'h0123, exp_line}) begin
        errors++;
        $display("FAIL fill_commit: got %h expected %h", commit_q[0], {14'h0123, exp_line});
      end
    end
    checks++;
    if (cmd_q.size() != 1 || cmd_q[0] !== {1'b0, 14'h0123}) begin
      errors++;
      $display("FAIL fill_cmd: got %0d cmds first %h expected 1 cmd %h", cmd_q.size(),
               cmd_q.size() > 0 ? cmd_q[0] : 15'h0, {1'b0, 14'h0123});
    end
    checks++;
    if (done_err_q.size() != 1 || done_err_q[0] !== 1'b0) begin
      errors++;
      $display("FAIL fill_done: got %0d pulses expected 1 with err=0", done_err_q.size());
    end else if (acc_cyc_q.size() == 1) begin
      checks++;
      if (done_cyc_q[0] - acc_cyc_q[0] != 7) begin
        errors++;
        $display("FAIL fill_latency: got %0d expected 7", done_cyc_q[0] - acc_cyc_q[0]);
      end
    end
  endtask

  task automatic test_writeback();
    logic [63:0] line;
    logic [15:0] exp_w [4];
    bit ok;
    line  = 64'hDDDD_CCCC_BBBB_AAAA;
    exp_w = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    clear_q();
    do_accept(14'h3FFF, 1'b1, 1'b0, ok);
    wb_body(line, 0, 0);
    for (int n = 0; n < 10 && done_err_q.size() == 0; n++) tick();
    checks++;
    if (cmd_q.size() != 1 || cmd_q[0] !== {1'b1, 14'h3FFF}) begin
      errors++;
      $display("FAIL wb_cmd: got %0d cmds first %h expected 1 cmd %h", cmd_q.size(),
               cmd_q.size() > 0 ? cmd_q[0] : 15'h0, {1'b1, 14'h3FFF});
    end
    checks++;
    if (wb_q.size() != 4) begin
      errors++;
      $display("FAIL wb_beat_count: got %0d expected 4", wb_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wb_q[k] !== exp_w[k]) begin
          errors++;
          $display("FAIL wb_beat%0d: got %h expected %h", k, wb_q[k], exp_w[k]);
        end
      end
    end
    checks++;
    if (commit_q.size() != 0 || done_err_q.size() != 1 || done_err_q[0] !== 1'b0) begin
      errors++;
      $display("FAIL wb_done: got commits=%0d dones=%0d expected commits=0 dones=1 err=0",
               commit_q.size(), done_err_q.size());
    end
  endtask

  task automatic test_conflict();
    logic [15:0] beats [4];
    logic [63:0] exp_line;
    logic [13:0] a;
    bit ok;
    a        = 14'($urandom());
    exp_line = '0;
    for (int k = 0; k < 4; k++) begin
      beats[k] = 16'($urandom());
      exp_line |= 64'(beats[k]) << (16 * k);
    end
    clear_q();
    do_accept(a, 1'b0, 1'b0, ok);
    fill_body(beats, 2, 5);
    for (int n = 0; n < 10 && done_err_q.size() == 0; n++) tick();
    checks++;
    if (stall_q.size() != 5) begin
      errors++;
      $display("FAIL conflict_stall_cycles: got %0d expected 5", stall_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (stall_q[k] !== {4'hF, a, exp_line}) begin
          errors++;
          $display("FAIL conflict_hold%0d: got %h expected %h", k, stall_q[k],
                   {4'hF, a, exp_line});
        end
      end
    end
    checks++;
    if (commit_q.size() != 1 || commit_q[0] !== {a, exp_line}) begin
      errors++;
      $display("FAIL conflict_commit: got %0d commits expected 1 of %h", commit_q.size(),
               {a, exp_line});
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit ok;
    clear_q();
    do_accept(14'h00A5, 1'b0, 1'b0, ok);
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    mem_rvalid    = 1'b1;
    mem_rdata     = 16'h5A5A;
    tick();
    mem_rdata = 16'hA5A5;
    tick();
    mem_rvalid = 1'b0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!done || n < int'(TO) || n > int'(TO) + 2) begin
      errors++;
      $display("FAIL timeout_done: done=%b after %0d cycles expected 1 after %0d..%0d",
               done, n, TO, TO + 2);
    end
    checks++;
    if (err !== 1'b1 || mem_cmd_valid !== 1'b0 || mem_wvalid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: got err=%b cmd_valid=%b wvalid=%b expected 1 0 0",
               err, mem_cmd_valid, mem_wvalid);
    end
    tick();
    checks++;
    if (commit_q.size() != 0 || done_err_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_nowrite: got commits=%0d dones=%0d expected 0 and 1",
               commit_q.size(), done_err_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] line;
    bit ok;
    line = {$urandom(), $urandom()};
    clear_q();
    do_accept(14'($urandom()), 1'b1, 1'b0, ok);
    cache_en = 1'b1;
    tick();
    cache_en    = 1'b0;
    cache_rdata = line;
    tick();
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    mem_wready    = 1'b1;
    tick();
    tick();
    mem_wready = 1'b0;
    checks++;
    if (mem_wvalid !== 1'b1 || mem_wdata !== 16'(line >> 32)) begin
      errors++;
      $display("FAIL rstmid_word2: got wvalid=%b data=%h expected 1 %h", mem_wvalid,
               mem_wdata, 16'(line >> 32));
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== ResetOuts) begin
      errors++;
      $display("FAIL rstmid_outs: got %h expected %h", all_outs(), ResetOuts);
    end
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (req_ready !== 1'b1 || done_err_q.size() != 0 || commit_q.size() != 0 ||
        wb_q.size() != 2) begin
      errors++;
      $display("FAIL rstmid_after: got ready=%b dones=%0d commits=%0d beats=%0d expected 1 0 0 2",
               req_ready, done_err_q.size(), commit_q.size(), wb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] beats [4];
    logic [63:0] exp_line, line;
    logic [13:0] a, b;
    bit ok;
    a        = 14'($urandom());
    b        = 14'($urandom());
    line     = {$urandom(), $urandom()};
    exp_line = '0;
    for (int k = 0; k < 4; k++) begin
      beats[k] = 16'($urandom());
      exp_line |= 64'(beats[k]) << (16 * k);
    end
    clear_q();
    do_accept(a, 1'b0, 1'b1, ok);
    fill_body(beats, 1, 1);
    req_addr  = b;
    req_write = 1'b1;
    tick();
    tick();
    req_valid = 1'b0;
    wb_body(line, 1, 1);
    for (int n = 0; n < 10 && done_err_q.size() < 2; n++) tick();
    tick();
    checks++;
    if (acc_cyc_q.size() != 2 || done_cyc_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_counts: got accepts=%0d dones=%0d expected 2 2", acc_cyc_q.size(),
               done_cyc_q.size());
    end else begin
      checks++;
      if (acc_cyc_q[1] != done_cyc_q[0] + 1) begin
        errors++;
        $display("FAIL b2b_accept_cycle: got %0d expected %0d", acc_cyc_q[1],
                 done_cyc_q[0] + 1);
      end
    end
    checks++;
    if (commit_q.size() != 1 || commit_q[0] !== {a, exp_line}) begin
      errors++;
      $display("FAIL b2b_fill: got %0d commits expected 1 of %h", commit_q.size(),
               {a, exp_line});
    end
    checks++;
    if (cmd_q.size() != 2 || cmd_q[0] !== {1'b0, a} || cmd_q[1] !== {1'b1, b}) begin
      errors++;
      $display("FAIL b2b_cmds: got %0d cmds expected %h then %h", cmd_q.size(), {1'b0, a},
               {1'b1, b});
    end
    checks++;
    if (wb_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_wb_count: got %0d expected 4", wb_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wb_q[k] !== 16'(line >> (16 * k))) begin
          errors++;
          $display("FAIL b2b_wb%0d: got %h expected %h", k, wb_q[k], 16'(line >> (16 * k)));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] beats [4];
    logic [63:0] exp_line, line;
    logic [13:0] a;
    logic        w;
    bit ok;
    for (int it = 0; it < 8; it++) begin
      a        = 14'($urandom());
      w        = 1'($urandom_range(1, 0));
      line     = {$urandom(), $urandom()};
      exp_line = '0;
      for (int k = 0; k < 4; k++) begin
        beats[k] = 16'($urandom());
        exp_line |= 64'(beats[k]) << (16 * k);
      end
      clear_q();
      do_accept(a, w, 1'b0, ok);
      if (w) wb_body(line, 3, $urandom_range(3, 0));
      else fill_body(beats, 3, $urandom_range(3, 0));
      for (int n = 0; n < 10 && done_err_q.size() == 0; n++) tick();
      checks++;
      if (cmd_q.size() != 1 || cmd_q[0] !== {w, a} || done_err_q.size() != 1 ||
          done_err_q[0] !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_cmd_done: got cmds=%0d dones=%0d expected 1 cmd %h, 1 done err=0",
                 it, cmd_q.size(), done_err_q.size(), {w, a});
      end
      if (w) begin
        checks++;
        if (commit_q.size() != 0 || wb_q.size() != 4) begin
          errors++;
          $display("FAIL rand%0d_wb_count: got commits=%0d beats=%0d expected 0 4", it,
                   commit_q.size(), wb_q.size());
        end else begin
          for (int k = 0; k < 4; k++) begin
            checks++;
            if (wb_q[k] !== 16'(line >> (16 * k))) begin
              errors++;
              $display("FAIL rand%0d_wb%0d: got %h expected %h", it, k, wb_q[k],
                       16'(line >> (16 * k)));
            end
          end
        end
      end else begin
        checks++;
        if (commit_q.size() != 1 || commit_q[0] !== {a, exp_line} || wb_q.size() != 0) begin
          errors++;
          $display("FAIL rand%0d_fill: got %0d commits first %h expected 1 of %h", it,
                   commit_q.size(), commit_q.size() > 0 ? commit_q[0] : 78'h0,
                   {a, exp_line});
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    req_addr  = 14'h0;
    req_write = 1'b0;
    test_reset();
    test_fill();
    test_writeback();
    test_conflict();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
